// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction fields, flags and datapath controls of the multicycle controller
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Lt;
    logic       MemReady;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       Retire;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, Lt, MemReady,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        output IRWrite, PCWrite, RegWrite, MemWrite, Retire, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Lt, MemReady,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        input  IRWrite, PCWrite, RegWrite, MemWrite, Retire, Illegal
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control sequencer with ALU/immediate decode and trap
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BRANCH_EXT    = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_JALRADR, S_JAL, S_BRANCH, S_ALUWB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    state_t     state, state_next, view;
    logic       ready, illegal_f3, taken;
    logic [2:0] imm;
    logic [1:0] src_a, src_b, res, alu_op;
    logic       adr, ir_write, pc_update, branch, reg_write, mem_write, trap;

    assign ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

    always_comb begin
        illegal_f3 = 1'b0;
        case (bus.op)
            OP_R, OP_I: illegal_f3 = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b011) ||
                                     (bus.funct3 == 3'b101);
            OP_BR: begin
                case (bus.funct3)
                    3'b000:                 illegal_f3 = 1'b0;
                    3'b001, 3'b100, 3'b101: illegal_f3 = !BRANCH_EXT;
                    default:                illegal_f3 = 1'b1;
                endcase
            end
            default: illegal_f3 = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (ready) state_next = S_DECODE;
            S_DECODE: begin
                if (illegal_f3) state_next = S_TRAP;
                else begin
                    case (bus.op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECR;
                        OP_I:         state_next = S_EXECI;
                        OP_LUI:       state_next = S_LUI;
                        OP_JALR:      state_next = S_JALRADR;
                        OP_JAL:       state_next = S_JAL;
                        OP_BR:        state_next = S_BRANCH;
                        default:      state_next = S_TRAP;
                    endcase
                end
            end
            S_MEMADR:   state_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_JAL: state_next = S_ALUWB;
            S_JALRADR:  state_next = S_JAL;
            S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Selects follow the FETCH decode while reset is held so the datapath sees a clean fetch.
    always_comb begin
        view      = reset ? S_FETCH : state;
        imm       = 3'b000;
        src_a     = 2'b00;
        src_b     = 2'b00;
        res       = 2'b00;
        adr       = 1'b0;
        alu_op    = ALU_ADD;
        ir_write  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        trap      = 1'b0;
        case (view)
            S_FETCH: begin
                src_b = 2'b10; res = 2'b10; ir_write = ready; pc_update = ready;
            end
            S_DECODE: begin
                src_a = 2'b01; src_b = 2'b01;
                imm   = (bus.op == OP_BR) ? 3'b010 : (bus.op == OP_JAL) ? 3'b011 : 3'b000;
            end
            S_MEMADR: begin
                src_a = 2'b10; src_b = 2'b01; imm = (bus.op == OP_SW) ? 3'b001 : 3'b000;
            end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWB:    begin res = 2'b01; reg_write = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mem_write = 1'b1; end
            S_EXECR:    begin src_a = 2'b10; alu_op = ALU_FUNC; end
            S_EXECI:    begin src_a = 2'b10; src_b = 2'b01; alu_op = ALU_FUNC; end
            S_LUI:      begin src_a = 2'b11; src_b = 2'b01; imm = 3'b100; end
            S_JALRADR:  begin src_a = 2'b10; src_b = 2'b01; end
            S_JAL:      begin src_a = 2'b01; src_b = 2'b10; pc_update = 1'b1; end
            S_BRANCH:   begin src_a = 2'b10; alu_op = ALU_SUB; branch = 1'b1; end
            S_ALUWB:    reg_write = 1'b1;
            S_TRAP:     trap = 1'b1;
            default:    trap = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.Lt;
            3'b101:  taken = ~bus.Lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_ADD: bus.ALUControl = 3'b000;
            ALU_SUB: bus.ALUControl = 3'b001;
            default: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b100:  bus.ALUControl = 3'b100;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    assign bus.ImmSrc    = imm;
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.ResultSrc = res;
    assign bus.AdrSrc    = adr;
    assign bus.IRWrite   = ir_write & ~reset;
    assign bus.PCWrite   = (pc_update | (branch & taken)) & ~reset;
    assign bus.RegWrite  = reg_write & ~reset;
    assign bus.MemWrite  = mem_write & ~reset;
    assign bus.Illegal   = trap & ~reset;
    assign bus.Retire    = ~reset && (state != S_FETCH) && (state_next == S_FETCH);
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed and randomized checks of mc_controller against a phase-plan model
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
    localparam int P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_LUI = 8, P_JALRADR = 9;
    localparam int P_JAL = 10, P_BRANCH = 11, P_ALUWB = 12, P_TRAP = 13;

    logic [6:0] in_op[2];
    logic [2:0] in_f3[2];
    logic       in_f7[2], in_z[2], in_lt[2], in_rdy[2];
    logic [18:0] act[2];

    mc_controller_if bus0 ();
    mc_controller_if bus1 ();

    mc_controller #(.MEM_HANDSHAKE(1'b1), .BRANCH_EXT(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mc_controller #(.MEM_HANDSHAKE(1'b0), .BRANCH_EXT(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.op = in_op[0];  assign bus0.funct3 = in_f3[0]; assign bus0.funct7b5 = in_f7[0];
    assign bus0.Zero = in_z[0]; assign bus0.Lt = in_lt[0];     assign bus0.MemReady = in_rdy[0];
    assign bus1.op = in_op[1];  assign bus1.funct3 = in_f3[1]; assign bus1.funct7b5 = in_f7[1];
    assign bus1.Zero = in_z[1]; assign bus1.Lt = in_lt[1];     assign bus1.MemReady = in_rdy[1];

    assign act[0] = {bus0.ImmSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc, bus0.AdrSrc, bus0.ALUControl,
                     bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite, bus0.Retire, bus0.Illegal};
    assign act[1] = {bus1.ImmSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ResultSrc, bus1.AdrSrc, bus1.ALUControl,
                     bus1.IRWrite, bus1.PCWrite, bus1.RegWrite, bus1.MemWrite, bus1.Retire, bus1.Illegal};

    int n_pass, n_total;
    int ph[2];
    int plan[2][3];
    int plen[2], pidx[2];

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", name, a, e);
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic lt, input logic rdy);
        for (int i = 0; i < 2; i++) begin
            in_op[i] = op; in_f3[i] = f3; in_f7[i] = f7; in_z[i] = z; in_lt[i] = lt; in_rdy[i] = rdy;
        end
    endtask

    task automatic set_plan(input int i, input int a, input int b, input int c, input int n);
        plan[i][0] = a; plan[i][1] = b; plan[i][2] = c; plen[i] = n;
    endtask

    // Instance 0 has the branch extension, instance 1 does not.
    task automatic build_plan(input int i);
        logic [2:0] f;
        f = in_f3[i];
        case (in_op[i])
            7'b0000011: set_plan(i, P_MEMADR, P_MEMREAD, P_MEMWB, 3);
            7'b0100011: set_plan(i, P_MEMADR, P_MEMWRITE, 0, 2);
            7'b0110011, 7'b0010011: begin
                if (f == 3'd1 || f == 3'd3 || f == 3'd5) set_plan(i, P_TRAP, 0, 0, 1);
                else set_plan(i, (in_op[i] == 7'b0110011) ? P_EXECR : P_EXECI, P_ALUWB, 0, 2);
            end
            7'b0110111: set_plan(i, P_LUI, P_ALUWB, 0, 2);
            7'b1100111: set_plan(i, P_JALRADR, P_JAL, P_ALUWB, 3);
            7'b1101111: set_plan(i, P_JAL, P_ALUWB, 0, 2);
            7'b1100011: begin
                if (f == 3'd0 || (i == 0 && (f == 3'd1 || f == 3'd4 || f == 3'd5)))
                    set_plan(i, P_BRANCH, 0, 0, 1);
                else set_plan(i, P_TRAP, 0, 0, 1);
            end
            default: set_plan(i, P_TRAP, 0, 0, 1);
        endcase
    endtask

    task automatic advance(input int i, output int nph, output int nidx);
        logic rdy;
        rdy  = (i == 1) ? 1'b1 : in_rdy[i];
        nph  = ph[i];
        nidx = pidx[i];
        case (ph[i])
            P_FETCH:  if (rdy) nph = P_DECODE;
            P_DECODE: begin build_plan(i); nph = plan[i][0]; nidx = 1; end
            P_TRAP:   nph = P_TRAP;
            default: begin
                if ((ph[i] == P_MEMREAD || ph[i] == P_MEMWRITE) && !rdy) nph = ph[i];
                else if (pidx[i] < plen[i]) begin nph = plan[i][pidx[i]]; nidx = pidx[i] + 1; end
                else nph = P_FETCH;
            end
        endcase
    endtask

    function automatic logic [2:0] alu_func(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_taken(input logic [2:0] f3, input logic z, input logic lt);
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        if (f3 == 3'b100) return lt;
        if (f3 == 3'b101) return !lt;
        return 1'b0;
    endfunction

    task automatic expected(input int i, output logic [18:0] e);
        int v, nph, nidx;
        logic [2:0] imm, alu;
        logic [1:0] a, b, res;
        logic adr, irw, pcw, rw, mw, ret, ill, rdy;
        rdy = (i == 1) ? 1'b1 : in_rdy[i];
        v = reset ? P_FETCH : ph[i];
        imm = 0; alu = 0; a = 0; b = 0; res = 0; adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
        case (v)
            P_FETCH:    begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            P_DECODE:   begin a = 2'b01; b = 2'b01;
                        imm = (in_op[i] == 7'b1100011) ? 3'b010 : (in_op[i] == 7'b1101111) ? 3'b011 : 3'b000; end
            P_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (in_op[i] == 7'b0100011) ? 3'b001 : 3'b000; end
            P_MEMREAD:  adr = 1'b1;
            P_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            P_EXECR:    begin a = 2'b10; alu = alu_func(in_op[i], in_f3[i], in_f7[i]); end
            P_EXECI:    begin a = 2'b10; b = 2'b01; alu = alu_func(in_op[i], in_f3[i], in_f7[i]); end
            P_LUI:      begin a = 2'b11; b = 2'b01; imm = 3'b100; end
            P_JALRADR:  begin a = 2'b10; b = 2'b01; end
            P_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            P_BRANCH:   begin a = 2'b10; alu = 3'b001; pcw = is_taken(in_f3[i], in_z[i], in_lt[i]); end
            P_ALUWB:    rw = 1'b1;
            default:    ill = 1'b1;
        endcase
        advance(i, nph, nidx);
        ret = (ph[i] != P_FETCH) && (nph == P_FETCH);
        if (reset) begin irw = 0; pcw = 0; rw = 0; mw = 0; ret = 0; ill = 0; end
        e = {imm, a, b, res, adr, alu, irw, pcw, rw, mw, ret, ill};
    endtask

    task automatic cyc();
        logic [18:0] e;
        int nph, nidx;
        #1;
        for (int i = 0; i < 2; i++) begin
            expected(i, e);
            n_total++;
            if (act[i] === e) n_pass++;
            else $display("FAIL model_dut%0d phase=%0d got=%b expected=%b", i, ph[i], act[i], e);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin ph[i] = P_FETCH; pidx[i] = 0; end
            else begin advance(i, nph, nidx); ph[i] = nph; pidx[i] = nidx; end
        end
        @(negedge clk);
    endtask

    logic [6:0] lw_tab[5];
    logic [6:0] ops[9];
    int trap_cnt;

    initial begin
        lw_tab = '{7'b0001000, 7'b0100000, 7'b1000000, 7'b0010000, 7'b0000111};
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                7'b1100111, 7'b1101111, 7'b1100011, 7'b1110011};
        n_pass = 0; n_total = 0; trap_cnt = 0;
        for (int i = 0; i < 2; i++) begin ph[i] = P_FETCH; pidx[i] = 0; plen[i] = 0; end
        reset = 1'b1;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1 lit("reset_enables", {bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite, bus0.Retire, bus0.Illegal}, 0);
        lit("reset_selects", {bus0.ALUSrcB, bus0.ResultSrc}, 4'b1010);
        cyc(); cyc();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 lit("lw_seq", {bus0.ALUSrcA, bus0.AdrSrc, bus0.ResultSrc, bus0.RegWrite, bus0.Retire}, lw_tab[c]);
            cyc();
        end

        set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        #1 lit("execr_sub", bus0.ALUControl, 3'b001);
        lit("execr_src", {bus0.ALUSrcA, bus0.ALUSrcB}, 4'b1000);
        cyc();
        #1 lit("r_aluwb", {bus0.RegWrite, bus0.ResultSrc, bus0.Retire}, 4'b1001);
        cyc();
        set_in(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        for (int c = 0; c < 10; c++) begin
            #1 lit("trap_hold", {bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite, bus0.Retire, bus0.Illegal}, 6'b000001);
            cyc();
        end
        reset = 1'b1;
        #1 lit("trap_reset", {bus0.Illegal, bus0.IRWrite}, 2'b00);
        cyc();
        reset = 1'b0;
        set_in(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 lit("after_trap_fetch", {bus0.ResultSrc, bus0.IRWrite}, 3'b101);
        cyc();
        #1 lit("decode_immb", bus0.ImmSrc, 3'b010);
        cyc();
        #1 lit("bne_taken", {bus0.PCWrite, bus0.Retire, bus0.ALUControl}, 5'b11001);
        lit("bne_noext_trap", bus1.Illegal, 1'b1);
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        set_in(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(); cyc();
        #1 lit("bne_not_taken", {bus0.PCWrite, bus0.Retire}, 2'b01);
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;

        set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 lit("fetch_wait", {bus0.IRWrite, bus0.PCWrite}, 2'b00);
            cyc();
        end
        in_rdy[0] = 1'b1; in_rdy[1] = 1'b1;
        #1 lit("fetch_ready", {bus0.IRWrite, bus0.PCWrite}, 2'b11);
        cyc();
        #1 lit("fetch_once", {bus0.IRWrite, bus0.PCWrite}, 2'b00);
        cyc();
        #1 lit("sw_imms", bus0.ImmSrc, 3'b001);
        cyc();
        in_rdy[0] = 1'b0; in_rdy[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1 lit("sw_wait", {bus0.MemWrite, bus0.Retire}, 2'b10);
            cyc();
        end
        in_rdy[0] = 1'b1; in_rdy[1] = 1'b1;
        #1 lit("sw_done", {bus0.MemWrite, bus0.Retire}, 2'b11);
        cyc();

        set_in(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        #1 lit("jalradr", {bus0.ImmSrc, bus0.ALUSrcA, bus0.ALUSrcB}, 7'b0001001);
        cyc();
        #1 lit("jalr_jal", {bus0.PCWrite, bus0.ALUSrcA, bus0.ALUSrcB}, 5'b10110);
        cyc();
        #1 lit("jalr_aluwb", {bus0.RegWrite, bus0.ResultSrc, bus0.Retire}, 4'b1001);
        cyc();

        set_in(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        #1 lit("lui_srcs", {bus0.ALUSrcA, bus0.ImmSrc}, 5'b11100);
        reset = 1'b1;
        #1 lit("lui_reset", {bus0.RegWrite, bus0.ALUSrcA, bus0.ALUSrcB}, 5'b00010);
        cyc();
        reset = 1'b0;
        #1 lit("lui_abort_fetch", {bus0.RegWrite, bus0.ResultSrc, bus0.IRWrite}, 4'b0101);
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == P_FETCH || ph[i] == P_TRAP) begin
                    in_op[i] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
                    in_f3[i] = $urandom_range(0, 1) ? 3'b000 : 3'($urandom);
                    in_f7[i] = 1'($urandom);
                end
                in_z[i]   = 1'($urandom);
                in_lt[i]  = 1'($urandom);
                in_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            trap_cnt = (ph[0] == P_TRAP || ph[1] == P_TRAP) ? trap_cnt + 1 : 0;
            reset = ($urandom_range(0, 99) == 0) || (trap_cnt > 4);
            if (reset) trap_cnt = 0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle RISC-V control unit: a Moore micro-sequencer plus ALU and immediate decoders driving the shared-memory datapath. It extends the base instruction set (R, I-ALU, lw, sw, beq, jal) with lui, jalr, bne/blt/bge, an optional memory-ready handshake, an illegal-instruction trap and a per-instruction retire pulse. It sits between the instruction register and the datapath select and enable lines.

## Interface
- MEM_HANDSHAKE, 1, 1: Fetch/MemRead/MemWrite wait for MemReady; 0: MemReady is ignored and treated as 1.
- BRANCH_EXT, 1, 1: bne/blt/bge are legal; 0: only beq is legal, other branch funct3 values trap.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  opcode from the instruction register.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Lt  in  1  ALU signed less-than flag.
- MemReady  in  1  memory completes access this cycle.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc  out  1  0 PC, 1 Result.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath enables.
- Retire  out  1  one-cycle pulse in an instruction's final cycle.
- Illegal  out  1  high while in TRAP.

## Operation
- States and outputs. Any select not listed is 0.
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, IRWrite and PCUpdate gated by MemReady.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ImmSrc B/J per op, add.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ImmSrc I (lw) or S (sw), add.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite held high.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp func.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ImmSrc I, ALUOp func.
  - LUI: ALUSrcA 11, ALUSrcB 01, ImmSrc U, add.
  - JALRADR: ALUSrcA 10, ALUSrcB 01, ImmSrc I, add.
  - JAL: ALUSrcA 01, ALUSrcB 10, ResultSrc 00, add, PCUpdate.
  - BRANCH: ALUSrcA 10, ALUSrcB 00, ResultSrc 00, sub, Branch.
  - ALUWB: ResultSrc 00, RegWrite.
  - TRAP: Illegal.
- Transitions:
  - FETCH→DECODE when MemReady.
  - DECODE dispatches on op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR; 0010011 → EXECI.
    - 0110111 → LUI; 1100111 → JALRADR.
    - 1101111 → JAL; 1100011 → BRANCH.
    - Anything else → TRAP.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB when MemReady. MEMWRITE → FETCH when MemReady.
  - EXECR, EXECI and LUI → ALUWB. JALRADR → JAL → ALUWB.
  - MEMWB, ALUWB and BRANCH → FETCH.
  - TRAP holds until reset.
- Illegal funct3 is checked in DECODE and goes to TRAP:
  - R and I ALU ops: funct3 001, 011 or 101.
  - Branch: funct3 010 or 011; also 001/100/101 when BRANCH_EXT=0.
  - Branch funct3 110 and 111 are always illegal.
- ALU decode:
  - ALUOp add → 000; ALUOp sub → 001.
  - ALUOp func by funct3:
    - 000 → sub if funct7b5 & op[5], else add.
    - 010 → 101 (slt); 100 → 100 (xor); 110 → 011 (or); 111 → 010 (and).
- Branch taken:
  - beq: Zero. bne: ~Zero.
  - blt: Lt. bge: ~Lt.
- PCWrite = PCUpdate | (Branch & taken).
- Retire is high in a cycle whose next state is FETCH and whose state is not FETCH.

## Timing
- State register updates on the rising clk edge.
  - Select outputs are Moore, decoded from the state.
  - ALUControl and branch-taken are combinational from funct3/funct7b5/Zero/Lt.
- reset: sampled at the edge, next state FETCH.
  - While reset is high, IRWrite, PCWrite, RegWrite, MemWrite, Retire and Illegal are forced 0.
  - Selects show FETCH values.
- Reset mid-instruction aborts the instruction with no further write enables.
- Zero-wait latencies:
  - branch 3 cycles.
  - R, I, sw, jal, lui 4 cycles.
  - lw, jalr 5 cycles.
  - Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- IRWrite and PCWrite pulse exactly once per FETCH, in the MemReady cycle.

## Test plan
- reset 2 cycles, lw, MemReady=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; Retire in cycle 5.
- R-type funct3=000 funct7b5=1 → EXECR ALUControl=001; ALUWB RegWrite=1; funct3=001 → Illegal=1 and all enables 0 for 10 cycles, then reset → FETCH.
- bne Zero=0 → PCWrite=1 in BRANCH; Zero=1 → PCWrite=0. With BRANCH_EXT=0, bne → TRAP.
- FETCH with MemReady=0 for 3 cycles → IRWrite=0, PCWrite=0 for 3 cycles, then 1 for exactly one cycle; sw MemWrite=1 is held across the wait.
- jalr → JALRADR (ImmSrc=000, ALUSrcA=10), JAL PCWrite=1, ALUWB RegWrite=1 with ResultSrc=00; total 5 cycles.
- lui → LUI ALUSrcA=11, ImmSrc=100; reset asserted in LUI → no RegWrite, FETCH next cycle.
